// File: rtl/stage_memory_wb.sv
// Memory-access stage: issues load/store requests to data memory over a
// req/ready handshake, stalls the pipeline while an access is outstanding,
// and registers the writeback bus (enable, destination, value) for decode.
module stage_memory_wb #(
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_reg_write,
  input  logic        mem_mem_write,
  input  logic [1:0]  mem_result_src,
  input  logic [31:0] mem_alu_result,
  input  logic [31:0] mem_write_data,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_pc_plus_4,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic        mem_fault,
  output logic [31:0] mem_fwd_value,
  output logic        wb_reg_write,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_result
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_e;

  // Final WAIT cycle index; reaching it without ready aborts the access.
  localparam logic [7:0] LAST_WAIT = 8'(WAIT_LIMIT - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        fault_q, fault_d;
  logic        wb_rw_q, wb_rw_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_res_q, wb_res_d;

  logic        is_mem;
  logic        misaligned;
  logic        start;
  logic        stall_raw;
  logic [31:0] load_data;

  assign is_mem     = mem_mem_write | (mem_result_src == 2'b01);
  assign misaligned = is_mem & (mem_alu_result[1:0] != 2'b00);
  assign start      = is_mem & ~misaligned;

  // Forwarding tap for the hazard unit: link value for jumps, ALU otherwise.
  always_comb begin
    mem_fwd_value = mem_alu_result;
    if (mem_result_src == 2'b10) begin
      mem_fwd_value = mem_pc_plus_4;
    end
  end

  // Next-state, handshake, fault and stall decode for the access FSM.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    fault_d   = 1'b0;
    stall_raw = 1'b0;
    load_data = '0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          stall_raw = 1'b1;
          state_d   = S_WAIT;
          req_d     = 1'b1;
          we_d      = mem_mem_write;
          addr_d    = {mem_alu_result[31:2], 2'b00};
          wdata_d   = mem_write_data;
          cnt_d     = '0;
        end else if (misaligned) begin
          fault_d = 1'b1;
        end
      end
      S_WAIT: begin
        // Ready is checked first so that it wins over a coinciding timeout.
        if (dmem_ready) begin
          state_d   = S_IDLE;
          req_d     = 1'b0;
          load_data = dmem_rdata;
        end else if (cnt_q == LAST_WAIT) begin
          state_d = S_IDLE;
          req_d   = 1'b0;
          fault_d = 1'b1;
        end else begin
          stall_raw = 1'b1;
          cnt_d     = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Writeback register input: bubble while stalled, otherwise select by source.
  always_comb begin
    wb_rw_d  = 1'b0;
    wb_rd_d  = '0;
    wb_res_d = '0;
    if (!stall_raw) begin
      wb_rw_d = mem_reg_write;
      wb_rd_d = mem_rd;
      unique case (mem_result_src)
        2'b01:   wb_res_d = load_data;
        2'b10:   wb_res_d = mem_pc_plus_4;
        default: wb_res_d = mem_alu_result;
      endcase
    end
  end

  // FSM state, wait counter and registered memory request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      fault_q <= fault_d;
    end
  end

  // Writeback bus register feeding the register-file write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_rw_q  <= 1'b0;
      wb_rd_q  <= '0;
      wb_res_q <= '0;
    end else begin
      wb_rw_q  <= wb_rw_d;
      wb_rd_q  <= wb_rd_d;
      wb_res_q <= wb_res_d;
    end
  end

  // Stall is forced low while reset is held so the hazard unit releases at once
  // even if the upstream register still presents a memory instruction.
  assign mem_stall    = stall_raw & ~rst;
  assign mem_fault    = fault_q;
  assign dmem_req     = req_q;
  assign dmem_we      = we_q;
  assign dmem_addr    = addr_q;
  assign dmem_wdata   = wdata_q;
  assign wb_reg_write = wb_rw_q;
  assign wb_rd        = wb_rd_q;
  assign wb_result    = wb_res_q;

endmodule

// File: tb/tb_stage_memory_wb.sv
// Directed bench for stage_memory_wb with a writeback scoreboard queue.
module tb_stage_memory_wb;

  localparam int unsigned LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_reg_write, mem_mem_write;
  logic [1:0]  mem_result_src;
  logic [31:0] mem_alu_result, mem_write_data, mem_pc_plus_4;
  logic [4:0]  mem_rd;
  logic        dmem_req, dmem_we, dmem_ready;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        mem_stall, mem_fault;
  logic [31:0] mem_fwd_value;
  logic        wb_reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_result;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        rw;
    logic [4:0]  rd;
    logic [31:0] res;
  } wb_t;

  wb_t sb[$];

  stage_memory_wb #(.WAIT_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .mem_reg_write(mem_reg_write), .mem_mem_write(mem_mem_write),
    .mem_result_src(mem_result_src), .mem_alu_result(mem_alu_result),
    .mem_write_data(mem_write_data), .mem_rd(mem_rd),
    .mem_pc_plus_4(mem_pc_plus_4),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .mem_stall(mem_stall), .mem_fault(mem_fault), .mem_fwd_value(mem_fwd_value),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_result(wb_result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_nop();
    mem_reg_write  = 1'b0;
    mem_mem_write  = 1'b0;
    mem_result_src = 2'b00;
    mem_alu_result = '0;
    mem_write_data = '0;
    mem_rd         = '0;
    mem_pc_plus_4  = '0;
    dmem_ready     = 1'b0;
  endtask

  // Present one instruction, play memory with ready on WAIT cycle ready_wait
  // (negative = never), and check the stage against an independent model.
  task automatic do_instr(input logic rw, input logic mw, input logic [1:0] src,
                          input logic [31:0] alu, input logic [31:0] wd,
                          input logic [31:0] pc4, input logic [4:0] rd,
                          input int ready_wait, input logic [31:0] rdata,
                          input string tag);
    bit  is_mem, mis, go, tmo, stall_obs;
    int  last, exp_stall, n_stall, n_req, c;
    wb_t e;
    is_mem = mw || (src == 2'b01);
    mis    = is_mem && (alu[1:0] != 2'b00);
    go     = is_mem && !mis;
    tmo    = 1'b0;
    last   = -1;
    if (go) begin
      if (ready_wait >= 0 && ready_wait < int'(LIMIT)) last = ready_wait;
      else begin
        last = int'(LIMIT) - 1;
        tmo  = 1'b1;
      end
    end
    exp_stall = last + 1;
    e.rw = rw;
    e.rd = rd;
    case (src)
      2'b01:   e.res = (go && !tmo) ? rdata : 32'h0;
      2'b10:   e.res = pc4;
      default: e.res = alu;
    endcase
    sb.push_back(e);

    mem_reg_write  = rw;
    mem_mem_write  = mw;
    mem_result_src = src;
    mem_alu_result = alu;
    mem_write_data = wd;
    mem_pc_plus_4  = pc4;
    mem_rd         = rd;
    dmem_rdata     = rdata;
    n_stall = 0;
    n_req   = 0;
    for (c = 0; c < 300; c++) begin
      dmem_ready = go && (c >= 1) && ((c - 1) == ready_wait);
      #4;
      stall_obs = mem_stall;
      if (mem_stall) n_stall++;
      if (dmem_req)  n_req++;
      chk({tag, " fwd"}, mem_fwd_value, (src == 2'b10) ? pc4 : alu);
      if (c >= 1) begin
        chk({tag, " bubble_rw"}, {31'b0, wb_reg_write}, 32'h0);
        chk({tag, " req_held"}, {31'b0, dmem_req}, 32'h1);
        chk({tag, " addr"}, dmem_addr, {alu[31:2], 2'b00});
        chk({tag, " we"}, {31'b0, dmem_we}, {31'b0, mw});
        chk({tag, " wdata"}, dmem_wdata, wd);
      end
      step();
      if (!stall_obs) break;
    end
    dmem_ready = 1'b0;
    chk({tag, " stall_cycles"}, n_stall, exp_stall);
    chk({tag, " req_cycles"}, n_req, exp_stall);
    chk({tag, " req_dropped"}, {31'b0, dmem_req}, 32'h0);
    chk({tag, " fault"}, {31'b0, mem_fault}, {31'b0, (go ? tmo : mis)});
    e = sb.pop_front();
    chk({tag, " wb_rw"}, {31'b0, wb_reg_write}, {31'b0, e.rw});
    chk({tag, " wb_rd"}, {27'b0, wb_rd}, {27'b0, e.rd});
    chk({tag, " wb_result"}, wb_result, e.res);
    drive_nop();
    step();
    chk({tag, " fault_pulse_end"}, {31'b0, mem_fault}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    dmem_rdata = '0;
    drive_nop();
    repeat (3) @(posedge clk);
    #4;
    chk("rst req",    {31'b0, dmem_req}, 32'h0);
    chk("rst we",     {31'b0, dmem_we}, 32'h0);
    chk("rst addr",   dmem_addr, 32'h0);
    chk("rst wdata",  dmem_wdata, 32'h0);
    chk("rst stall",  {31'b0, mem_stall}, 32'h0);
    chk("rst fault",  {31'b0, mem_fault}, 32'h0);
    chk("rst wb_rw",  {31'b0, wb_reg_write}, 32'h0);
    chk("rst wb_rd",  {27'b0, wb_rd}, 32'h0);
    chk("rst wb_res", wb_result, 32'h0);
    step();
    rst = 1'b0;

    do_instr(1'b1, 1'b0, 2'b00, 32'h0000_1234, 32'h0, 32'h0000_2000, 5'd5,  -1, 32'h0,         "alu");
    do_instr(1'b1, 1'b0, 2'b01, 32'h0000_0100, 32'h0, 32'h0000_0404, 5'd7,   0, 32'hDEAD_BEEF, "load0");
    do_instr(1'b0, 1'b1, 2'b00, 32'h0000_0200, 32'h0000_CAFE, 32'h0000_0408, 5'd0, 3, 32'h0,  "store3");
    do_instr(1'b1, 1'b0, 2'b01, 32'h0000_0102, 32'h0, 32'h0000_040C, 5'd9,  -1, 32'h0000_0055, "misld");
    do_instr(1'b0, 1'b1, 2'b00, 32'h0000_0203, 32'h0000_0077, 32'h0000_0410, 5'd0, -1, 32'h0, "misst");
    do_instr(1'b1, 1'b0, 2'b01, 32'h0000_0300, 32'h0, 32'h0000_0414, 5'd10, -1, 32'hAAAA_5555, "timeout");
    do_instr(1'b1, 1'b0, 2'b01, 32'h0000_0304, 32'h0, 32'h0000_0418, 5'd11,  3, 32'h1234_5678, "rdylast");
    do_instr(1'b1, 1'b0, 2'b10, 32'h0000_0050, 32'h0, 32'h0000_1000, 5'd31, -1, 32'h0,         "link");
    do_instr(1'b1, 1'b0, 2'b11, 32'h0000_0060, 32'h0, 32'h0000_2000, 5'd12, -1, 32'h0,         "src3");

    // Reset while an access is outstanding.
    mem_reg_write  = 1'b1;
    mem_result_src = 2'b01;
    mem_alu_result = 32'h0000_0400;
    mem_rd         = 5'd13;
    dmem_ready     = 1'b0;
    step();
    step();
    chk("midrst pre_req", {31'b0, dmem_req}, 32'h1);
    rst = 1'b1;
    #1;
    chk("midrst req",    {31'b0, dmem_req}, 32'h0);
    chk("midrst stall",  {31'b0, mem_stall}, 32'h0);
    chk("midrst wb_rw",  {31'b0, wb_reg_write}, 32'h0);
    chk("midrst wb_rd",  {27'b0, wb_rd}, 32'h0);
    chk("midrst wb_res", wb_result, 32'h0);
    drive_nop();
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #4;
      chk("postrst req",   {31'b0, dmem_req}, 32'h0);
      chk("postrst stall", {31'b0, mem_stall}, 32'h0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
